banked_sample_buffer: RTL and testbench



---
 rtl/banked_sample_buffer_if.sv | 20 ++
 rtl/banked_sample_buffer.sv | 224 ++++++++++++++++++++++
 tb/tb_banked_sample_buffer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/banked_sample_buffer_if.sv
// Stream interfaces for the sample buffer: a single AXI-Stream link with
// last, and a per-channel parallel bundle of data/valid/ready.
interface Axis_If #(parameter int W = 16);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;
    logic         last;

    modport master (output data, valid, last, input ready);
    modport slave  (input data, valid, last, output ready);
endinterface

interface Axis_Parallel_If #(parameter int N_CHANNELS = 8, parameter int W = 16);
    logic [N_CHANNELS-1:0][W-1:0] data;
    logic [N_CHANNELS-1:0]        valid;
    logic [N_CHANNELS-1:0]        ready;

    modport master (output data, valid, input ready);
    modport slave  (input data, valid, output ready);
endinterface

// File: rtl/banked_sample_buffer.sv
// Multichannel capture buffer: banks are chained per active channel during
// capture, then streamed out bank by bank as {channel, count, samples}.
//
// state   | meaning
// IDLE    | waiting for start; config accepted
// CAPTURE | writing active channels into their chained banks until full/stop
// READOUT | streaming every bank out on data_out; config not accepted
module banked_sample_buffer #(
    parameter int N_CHANNELS       = 8,
    parameter int BUFFER_DEPTH     = 1024,
    parameter int PARALLEL_SAMPLES = 1,
    parameter int SAMPLE_WIDTH     = 16
) (
    input  logic           clk,
    input  logic           reset,
    Axis_Parallel_If.slave data_in,
    Axis_If.master         data_out,
    Axis_If.slave          config_in
);
    localparam int W    = PARALLEL_SAMPLES * SAMPLE_WIDTH;
    localparam int BW   = $clog2(N_CHANNELS);
    localparam int AW   = $clog2(BUFFER_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int MW   = $clog2(BW + 1);
    localparam int WW   = AW + 2;

    typedef enum logic [1:0] {IDLE, CAPTURE, READOUT} state_t;

    state_t state_q, state_d;

    logic          cfg_fire, cfg_start, cfg_stop;
    logic [MW-1:0] cfg_mode, mode_clamped, mode_q;
    logic [BW:0]   n_act;
    logic [BW-1:0] mask;
    logic          unused_cfg_last;

    assign cfg_fire        = config_in.valid & config_in.ready;
    assign cfg_start       = cfg_fire & config_in.data[1];
    assign cfg_stop        = cfg_fire & config_in.data[0];
    assign cfg_mode        = config_in.data[2 +: MW];
    assign mode_clamped    = (cfg_mode > MW'(BW)) ? MW'(BW) : cfg_mode;
    assign config_in.ready = (state_q != READOUT);
    assign data_in.ready   = {N_CHANNELS{~reset}};
    assign unused_cfg_last = config_in.last;

    assign n_act = (BW+1)'(1) << mode_q;
    assign mask  = BW'(n_act - (BW+1)'(1));

    logic          out_pop;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_start) state_d = CAPTURE;
            CAPTURE: if (cfg_stop) state_d = READOUT;
            READOUT: if (out_pop && data_out.last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture: each channel tracks its current bank in the chain c, c+2^M, ...
    logic                capture_en_q;
    logic [BW-1:0]       cur_bank_q [N_CHANNELS];
    logic [CNTW-1:0]     count_q    [N_CHANNELS];
    logic [N_CHANNELS-1:0] ch_wr, ch_fill, ch_end, bank_we;
    logic [BW:0]         ch_next    [N_CHANNELS];
    logic [BW-1:0]       bank_ch    [N_CHANNELS];
    logic [W-1:0]        bank_wdata [N_CHANNELS];

    always_comb begin
        ch_wr   = '0;
        ch_fill = '0;
        ch_end  = '0;
        bank_we = '0;
        for (int c = 0; c < N_CHANNELS; c++) begin
            ch_wr[c]   = (state_q == CAPTURE) && capture_en_q && data_in.valid[c]
                         && ({1'b0, BW'(c)} < n_act);
            ch_fill[c] = ch_wr[c] && (count_q[cur_bank_q[c]] == CNTW'(BUFFER_DEPTH - 1));
            ch_next[c] = {1'b0, cur_bank_q[c]} + n_act;
            ch_end[c]  = ch_fill[c] && (ch_next[c] >= (BW+1)'(N_CHANNELS));
        end
        for (int b = 0; b < N_CHANNELS; b++) begin
            bank_ch[b]    = BW'(b) & mask;
            bank_we[b]    = ch_wr[bank_ch[b]] && (cur_bank_q[bank_ch[b]] == BW'(b));
            bank_wdata[b] = data_in.data[bank_ch[b]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q       <= '0;
            capture_en_q <= 1'b0;
            for (int c = 0; c < N_CHANNELS; c++) begin
                cur_bank_q[c] <= '0;
                count_q[c]    <= '0;
            end
        end else if (state_q == IDLE && cfg_start) begin
            mode_q       <= mode_clamped;
            capture_en_q <= 1'b1;
            for (int c = 0; c < N_CHANNELS; c++) begin
                cur_bank_q[c] <= BW'(c);
                count_q[c]    <= '0;
            end
        end else begin
            for (int b = 0; b < N_CHANNELS; b++)
                if (bank_we[b]) count_q[b] <= count_q[b] + CNTW'(1);
            for (int c = 0; c < N_CHANNELS; c++)
                if (ch_fill[c] && !ch_end[c]) cur_bank_q[c] <= ch_next[c][BW-1:0];
            if (|ch_end) capture_en_q <= 1'b0;
        end
    end

    // Readout sequencer walks (bank, word) and issues one item per cycle
    logic [BW-1:0]   rd_bank_q;
    logic [WW-1:0]   rd_word_q;
    logic            seq_done_q;
    logic [CNTW-1:0] cur_cnt;
    logic            item_is_sample, item_last_bank, item_last, issue;
    logic [W-1:0]    item_hdr;
    logic [AW-1:0]   rd_addr;
    logic [2:0]      occ;
    logic [N_CHANNELS-1:0][W-1:0] rd_all;

    for (genvar b = 0; b < N_CHANNELS; b++) begin : g_bank
        logic [W-1:0] mem [BUFFER_DEPTH];
        logic [W-1:0] rd_q;
        always_ff @(posedge clk) begin
            if (bank_we[b]) mem[count_q[b][AW-1:0]] <= bank_wdata[b];
            rd_q <= mem[rd_addr];
        end
        assign rd_all[b] = rd_q;
    end

    logic          p1_valid_q, p1_sample_q, p1_last_q;
    logic [W-1:0]  p1_hdr_q;
    logic [BW-1:0] p1_bank_q;

    logic [W-1:0]  fifo_data_q [2];
    logic          fifo_last_q [2];
    logic          head_q;
    logic [1:0]    cnt_q;
    logic          push, tail;
    logic [W-1:0]  push_data;

    assign cur_cnt        = count_q[rd_bank_q];
    assign item_is_sample = (rd_word_q >= WW'(2));
    assign item_last_bank = (rd_word_q == WW'(cur_cnt) + WW'(1));
    assign item_last      = item_last_bank && (rd_bank_q == BW'(N_CHANNELS - 1));
    assign item_hdr       = (rd_word_q == '0) ? W'(rd_bank_q & mask) : W'(cur_cnt);
    assign rd_addr        = AW'(rd_word_q - WW'(2));

    // Conservative credit: the issued item must still fit if the sink stalls next cycle
    assign occ   = {1'b0, cnt_q} - {2'b0, out_pop} + {2'b0, p1_valid_q};
    assign issue = (state_q == READOUT) && !seq_done_q && (occ <= 3'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_bank_q  <= '0;
            rd_word_q  <= '0;
            seq_done_q <= 1'b1;
        end else if (state_q == CAPTURE && cfg_stop) begin
            rd_bank_q  <= '0;
            rd_word_q  <= '0;
            seq_done_q <= 1'b0;
        end else if (issue) begin
            if (item_last_bank) begin
                rd_word_q <= '0;
                if (rd_bank_q == BW'(N_CHANNELS - 1)) seq_done_q <= 1'b1;
                else                                  rd_bank_q  <= rd_bank_q + BW'(1);
            end else begin
                rd_word_q <= rd_word_q + WW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p1_valid_q  <= 1'b0;
            p1_sample_q <= 1'b0;
            p1_last_q   <= 1'b0;
            p1_hdr_q    <= '0;
            p1_bank_q   <= '0;
        end else begin
            p1_valid_q  <= issue;
            p1_sample_q <= item_is_sample;
            p1_last_q   <= item_last;
            p1_hdr_q    <= item_hdr;
            p1_bank_q   <= rd_bank_q;
        end
    end

    // Two-entry output queue absorbs the one-cycle memory read latency
    assign push      = p1_valid_q;
    assign tail      = head_q ^ cnt_q[0];
    assign push_data = p1_sample_q ? rd_all[p1_bank_q] : p1_hdr_q;

    assign data_out.valid = (cnt_q != 2'd0);
    assign data_out.data  = fifo_data_q[head_q];
    assign data_out.last  = data_out.valid & fifo_last_q[head_q];
    assign out_pop        = data_out.valid & data_out.ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= 1'b0;
            cnt_q  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_data_q[tail] <= push_data;
                fifo_last_q[tail] <= p1_last_q;
            end
            if (out_pop) head_q <= ~head_q;
            cnt_q <= cnt_q + 2'(push) - 2'(out_pop);
        end
    end
endmodule

// File: tb/tb_banked_sample_buffer.sv
// Bench for banked_sample_buffer: random capture traffic recorded per channel,
// expected readout stream derived from channel totals and chain arithmetic.
module tb_banked_sample_buffer;
    localparam int N     = 8;
    localparam int D     = 1024;
    localparam int W     = 16;
    localparam int LOGN  = $clog2(N);
    localparam int MW    = $clog2(LOGN + 1);
    localparam int CFG_W = 2 + MW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    Axis_Parallel_If #(.N_CHANNELS(N), .W(W)) din ();
    Axis_If #(.W(W))     dout ();
    Axis_If #(.W(CFG_W)) cfg ();

    banked_sample_buffer #(
        .N_CHANNELS(N), .BUFFER_DEPTH(D), .PARALLEL_SAMPLES(1), .SAMPLE_WIDTH(W)
    ) dut (
        .clk(clk), .reset(reset), .data_in(din), .data_out(dout), .config_in(cfg)
    );

    int n_checks = 0;
    int n_pass = 0;

    typedef enum {M_IDLE, M_CAP, M_RO} mstate_t;
    mstate_t     m_state = M_IDLE;
    int          m_mode = 0;
    bit          m_stopped = 1'b1;
    logic [W-1:0] m_mem [N][N*D];
    int          m_cnt [N];
    logic [W-1:0] exp_data [$];
    bit          exp_last [$];

    task automatic cfg_cmd(input int mode, input bit start, input bit stop);
        din.valid = '0;
        cfg.data  = {MW'(mode), start, stop};
        cfg.valid = 1'b1;
        @(posedge clk);
        if (m_state == M_IDLE && start) begin
            m_state   = M_CAP;
            m_mode    = (mode > LOGN) ? LOGN : mode;
            m_stopped = 1'b0;
            for (int c = 0; c < N; c++) m_cnt[c] = 0;
        end else if (m_state == M_CAP && stop) begin
            m_state = M_RO;
        end
        #1 cfg.valid = 1'b0;
    endtask

    task automatic drive_cycle(input logic [N-1:0] v);
        int cap;
        cap = (N * D) >> m_mode;
        for (int c = 0; c < N; c++) din.data[c] = W'($urandom);
        din.valid = v;
        @(posedge clk);
        if (m_state == M_CAP && !m_stopped)
            for (int c = 0; c < N; c++)
                if (v[c] && c < (1 << m_mode)) begin
                    m_mem[c][m_cnt[c]] = din.data[c];
                    m_cnt[c]++;
                end
        for (int c = 0; c < N; c++) if (m_cnt[c] >= cap) m_stopped = 1'b1;
        #1;
    endtask

    task automatic build_expected();
        int n_act, c, k, n;
        exp_data.delete();
        exp_last.delete();
        n_act = 1 << m_mode;
        for (int b = 0; b < N; b++) begin
            c = b % n_act;
            k = b / n_act;
            n = m_cnt[c] - k * D;
            if (n < 0) n = 0;
            if (n > D) n = D;
            exp_data.push_back(W'(c));  exp_last.push_back(1'b0);
            exp_data.push_back(W'(n));  exp_last.push_back(b == N - 1 && n == 0);
            for (int i = 0; i < n; i++) begin
                exp_data.push_back(m_mem[c][k * D + i]);
                exp_last.push_back(b == N - 1 && i == n - 1);
            end
        end
    endtask

    task automatic read_out(input bit bp, input string name);
        int idx = 0, iter = 0, first = -1, limit;
        bit stalled = 1'b0, bad = 1'b0;
        logic [W-1:0] hold_d;
        logic hold_l;
        build_expected();
        limit = 4 * exp_data.size() + 50;
        while (idx < exp_data.size() && iter < limit) begin
            dout.ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (dout.valid && first < 0) first = iter;
            if (stalled) begin
                n_checks++;
                if (dout.valid !== 1'b1 || dout.data !== hold_d || dout.last !== hold_l)
                    $display("FAIL %s stall_hold: got valid=%b data=%h last=%b, need valid=1 data=%h last=%b",
                             name, dout.valid, dout.data, dout.last, hold_d, hold_l);
                else n_pass++;
            end
            stalled = dout.valid && !dout.ready;
            hold_d  = dout.data;
            hold_l  = dout.last;
            if (dout.valid && dout.ready) begin
                if (!bad) begin
                    n_checks++;
                    if (dout.data !== exp_data[idx] || dout.last !== exp_last[idx]) begin
                        $display("FAIL %s word %0d: got data=%h last=%b, need data=%h last=%b",
                                 name, idx, dout.data, dout.last, exp_data[idx], exp_last[idx]);
                        bad = 1'b1;
                    end else n_pass++;
                end
                idx++;
            end
            @(posedge clk);
            #1;
            iter++;
        end
        n_checks++;
        if (idx != exp_data.size())
            $display("FAIL %s word_count: got %0d words, need %0d", name, idx, exp_data.size());
        else n_pass++;
        n_checks++;
        if (first < 0 || first > 4)
            $display("FAIL %s first_valid_latency: got %0d cycles, need <= 4", name, first);
        else n_pass++;
        dout.ready = 1'b1;
        n_checks++;
        if (dout.valid !== 1'b0 || cfg.ready !== 1'b1)
            $display("FAIL %s back_to_idle: got valid=%b cfg_ready=%b, need valid=0 cfg_ready=1",
                     name, dout.valid, cfg.ready);
        else n_pass++;
        m_state = M_IDLE;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (din.ready !== '0) $display("FAIL rst_din_ready: got %b, need 0", din.ready);
        else n_pass++;
        n_checks++;
        if (dout.valid !== 1'b0 || dout.last !== 1'b0)
            $display("FAIL rst_valid_last: got valid=%b last=%b, need 0 0", dout.valid, dout.last);
        else n_pass++;
        n_checks++;
        if (dout.data !== '0) $display("FAIL rst_data: got %h, need 0", dout.data);
        else n_pass++;
        n_checks++;
        if (cfg.ready !== 1'b1) $display("FAIL rst_cfg_ready: got %b, need 1", cfg.ready);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if (din.ready !== {N{1'b1}}) $display("FAIL din_ready_run: got %b, need all ones", din.ready);
        else n_pass++;
        m_state = M_IDLE;
    endtask

    task automatic test_config_rules();
        cfg_cmd(0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (dout.valid !== 1'b0 || cfg.ready !== 1'b1)
                $display("FAIL idle_stop_ignored: got valid=%b cfg_ready=%b, need 0 1", dout.valid, cfg.ready);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        cfg_cmd(1, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) drive_cycle(N'($urandom));
        cfg_cmd(3, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) drive_cycle(N'($urandom));
        cfg_cmd(0, 1'b0, 1'b1);
        read_out(1'b1, "config_rules");
    endtask

    task automatic test_few_samples();
        logic [N-1:0] v;
        cfg_cmd(0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            v = N'($urandom);
            v[0] = 1'b1;
            drive_cycle(v);
        end
        cfg_cmd(0, 1'b0, 1'b1);
        read_out(1'b0, "few_samples");
    endtask

    task automatic test_spill();
        logic [N-1:0] v;
        cfg_cmd(1, 1'b1, 1'b0);
        for (int i = 0; i < (D - 5) / 2 * 8; i++) begin
            v = N'($urandom);
            v[1:0] = 2'b11;
            drive_cycle(v);
        end
        cfg_cmd(0, 1'b0, 1'b1);
        read_out(1'b0, "spill");
    endtask

    task automatic test_fill_all();
        cfg_cmd(3, 1'b1, 1'b0);
        for (int i = 0; i < D + 1; i++) drive_cycle({N{1'b1}});
        cfg_cmd(0, 1'b0, 1'b1);
        read_out(1'b0, "fill_all");
    endtask

    task automatic test_uneven_backpressure();
        int cyc = 0;
        cfg_cmd(2, 1'b1, 1'b0);
        while (!m_stopped && cyc < 20000) begin
            drive_cycle(N'($urandom));
            cyc++;
        end
        for (int i = 0; i < 12; i++) drive_cycle(N'($urandom));
        n_checks++;
        if (!m_stopped) $display("FAIL uneven_fill_reached: got cycles=%0d, need fill before 20000", cyc);
        else n_pass++;
        cfg_cmd(0, 1'b0, 1'b1);
        read_out(1'b1, "uneven_bp");
    endtask

    task automatic test_reset_readout();
        bit seen = 1'b0;
        cfg_cmd(2, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) drive_cycle(N'($urandom));
        cfg_cmd(0, 1'b0, 1'b1);
        dout.ready = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (dout.valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) $display("FAIL rro_valid_seen: got valid=%b, need 1 within 8 cycles", dout.valid);
        else n_pass++;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (dout.valid !== 1'b0) $display("FAIL rro_valid_drop: got %b, need 0", dout.valid);
        else n_pass++;
        reset = 1'b0;
        m_state = M_IDLE;
        dout.ready = 1'b1;
        cfg_cmd(3, 1'b1, 1'b0);
        cfg_cmd(0, 1'b0, 1'b1);
        read_out(1'b0, "post_reset");
    endtask

    initial begin
        din.valid  = '0;
        din.data   = '0;
        dout.ready = 1'b1;
        cfg.valid  = 1'b0;
        cfg.data   = '0;
        cfg.last   = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_config_rules();
        test_few_samples();
        test_spill();
        test_fill_all();
        test_uneven_backpressure();
        test_reset_readout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
